// File: rtl/motor_sequencer_if.sv
// Control/status bundle between the user/limit-switch side and the motor sequencer.
interface motor_sequencer_if;
    logic activate;
    logic up_limit;
    logic dn_limit;
    logic fault_clr;
    logic obstacle;
    logic motor_up;
    logic motor_dn;
    logic busy;
    logic fault;

    // Command/sensor side: drives the inputs and observes the drive/status outputs
    modport master (
        output activate, up_limit, dn_limit, fault_clr, obstacle,
        input  motor_up, motor_dn, busy, fault
    );

    // Sequencer side
    modport slave (
        input  activate, up_limit, dn_limit, fault_clr, obstacle,
        output motor_up, motor_dn, busy, fault
    );
endinterface

// File: rtl/motor_sequencer.sv
// Supervisory up/down motor sequencer: press-to-start/stop, dead-time before every
// start or reversal, travel timeout with latched fault, mutually exclusive drives.
// Optional macro OBSTACLE_REVERSE_EN: obstacle during a downward run reverses the
// motor after dead-time; obstacle during an upward run stops it.
module motor_sequencer #(
    parameter int unsigned DEAD_CYC    = 4,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    motor_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DEAD   = 3'd1,
        ST_RUN_UP = 3'd2,
        ST_RUN_DN = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_t;

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state, state_nxt;
    dir_t             last_dir, last_dir_nxt;
    dir_t             target, target_nxt;
    logic [CNT_W-1:0] dead_cnt, dead_cnt_nxt;
    logic [CNT_W-1:0] run_cnt, run_cnt_nxt;
    logic             act_q;
    logic             act_pulse_c;
    logic             both_limits_c;
    logic             motor_up_q, motor_dn_q, busy_q, fault_q;

    assign act_pulse_c   = bus.activate & ~act_q;
    assign both_limits_c = bus.up_limit & bus.dn_limit;

    // State, counters, direction memory and registered Moore outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_dir   <= DIR_DN;
            target     <= DIR_DN;
            dead_cnt   <= '0;
            run_cnt    <= '0;
            act_q      <= 1'b0;
            motor_up_q <= 1'b0;
            motor_dn_q <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_dir   <= last_dir_nxt;
            target     <= target_nxt;
            dead_cnt   <= dead_cnt_nxt;
            run_cnt    <= run_cnt_nxt;
            act_q      <= bus.activate;
            motor_up_q <= (state_nxt == ST_RUN_UP);
            motor_dn_q <= (state_nxt == ST_RUN_DN);
            busy_q     <= (state_nxt == ST_DEAD) || (state_nxt == ST_RUN_UP) ||
                          (state_nxt == ST_RUN_DN);
            fault_q    <= (state_nxt == ST_FAULT);
        end
    end

    // Next-state, counter and direction decisions
    always_comb begin
        state_nxt    = state;
        last_dir_nxt = last_dir;
        target_nxt   = target;
        dead_cnt_nxt = dead_cnt;
        run_cnt_nxt  = run_cnt;
        unique case (state)
            ST_IDLE: begin
                if (both_limits_c) begin
                    state_nxt = ST_FAULT;
                end else if (act_pulse_c) begin
                    state_nxt    = ST_DEAD;
                    dead_cnt_nxt = DEAD_LOAD;
                    if (bus.up_limit)      target_nxt = DIR_DN;
                    else if (bus.dn_limit) target_nxt = DIR_UP;
                    else                   target_nxt = (last_dir == DIR_UP) ? DIR_DN : DIR_UP;
                end
            end
            ST_DEAD: begin
                dead_cnt_nxt = dead_cnt - CNT_W'(1);
                if (act_pulse_c) begin
                    state_nxt = ST_IDLE;
                end else if (dead_cnt == CNT_W'(1)) begin
                    state_nxt   = (target == DIR_UP) ? ST_RUN_UP : ST_RUN_DN;
                    run_cnt_nxt = '0;
                end
            end
            ST_RUN_UP: begin
                run_cnt_nxt = run_cnt + CNT_W'(1);
                if (bus.up_limit) begin
                    state_nxt    = ST_IDLE;
                    last_dir_nxt = DIR_UP;
`ifdef OBSTACLE_REVERSE_EN
                end else if (bus.obstacle) begin
                    state_nxt    = ST_IDLE;
                    last_dir_nxt = DIR_UP;
`endif
                end else if (act_pulse_c) begin
                    state_nxt    = ST_IDLE;
                    last_dir_nxt = DIR_UP;
                end else if (run_cnt == RUN_LAST) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_RUN_DN: begin
                run_cnt_nxt = run_cnt + CNT_W'(1);
                if (bus.dn_limit) begin
                    state_nxt    = ST_IDLE;
                    last_dir_nxt = DIR_DN;
`ifdef OBSTACLE_REVERSE_EN
                end else if (bus.obstacle) begin
                    state_nxt    = ST_DEAD;
                    target_nxt   = DIR_UP;
                    dead_cnt_nxt = DEAD_LOAD;
`endif
                end else if (act_pulse_c) begin
                    state_nxt    = ST_IDLE;
                    last_dir_nxt = DIR_DN;
                end else if (run_cnt == RUN_LAST) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (bus.fault_clr && !both_limits_c) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.motor_up = motor_up_q;
    assign bus.motor_dn = motor_dn_q;
    assign bus.busy     = busy_q;
    assign bus.fault    = fault_q;

endmodule

// File: tb/tb_motor_sequencer.sv
// Directed self-checking bench for motor_sequencer (DEAD_CYC=4, TIMEOUT_CYC=20).
module tb_motor_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    motor_sequencer_if bus ();

    motor_sequencer #(
        .DEAD_CYC    (4),
        .TIMEOUT_CYC (20),
        .CNT_W       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic up, input logic dn,
                           input logic bsy, input logic flt);
        chk({tag, ".motor_up"}, bus.motor_up, up);
        chk({tag, ".motor_dn"}, bus.motor_dn, dn);
        chk({tag, ".busy"},     bus.busy,     bsy);
        chk({tag, ".fault"},    bus.fault,    flt);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.activate  = 1'b0;
        bus.up_limit  = 1'b0;
        bus.dn_limit  = 1'b0;
        bus.fault_clr = 1'b0;
        bus.obstacle  = 1'b0;
        step(2);
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // At lower stop: press runs UP after 4 dead cycles, up_limit stops it
        bus.dn_limit = 1'b1;
        step(1);
        bus.activate = 1'b1;
        step(1);
        chk_out("up_dead0", 1'b0, 1'b0, 1'b1, 1'b0);
        step(3);
        chk_out("up_dead3", 1'b0, 1'b0, 1'b1, 1'b0);
        step(1);
        chk_out("up_run", 1'b1, 1'b0, 1'b1, 1'b0);
        bus.activate = 1'b0;
        step(5);
        chk_out("up_run_opp_limit_ignored", 1'b1, 1'b0, 1'b1, 1'b0);
        bus.dn_limit = 1'b0;
        bus.up_limit = 1'b1;
        step(1);
        chk_out("up_limit_stop", 1'b0, 1'b0, 1'b0, 1'b0);

        // At upper stop with activate held: exactly one DN run
        bus.activate = 1'b1;
        step(1);
        chk_out("dn_dead0", 1'b0, 1'b0, 1'b1, 1'b0);
        step(4);
        chk_out("dn_run", 1'b0, 1'b1, 1'b1, 1'b0);
        bus.up_limit = 1'b0;
        step(10);
        chk_out("dn_held", 1'b0, 1'b1, 1'b1, 1'b0);
        bus.activate = 1'b0;
        step(1);
        chk_out("dn_release", 1'b0, 1'b1, 1'b1, 1'b0);
        bus.activate = 1'b1;
        step(1);
        chk_out("dn_press_stop", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.activate = 1'b0;
        step(1);

        // No limits, last_dir=DN -> UP run, which times out after 20 drive cycles
        bus.activate = 1'b1;
        step(1);
        bus.activate = 1'b0;
        step(4);
        chk_out("to_run_start", 1'b1, 1'b0, 1'b1, 1'b0);
        step(19);
        chk_out("to_run_last", 1'b1, 1'b0, 1'b1, 1'b0);
        step(1);
        chk_out("to_fault", 1'b0, 1'b0, 1'b0, 1'b1);
        step(3);
        chk_out("to_fault_latched", 1'b0, 1'b0, 1'b0, 1'b1);
        bus.fault_clr = 1'b1;
        step(1);
        chk_out("to_clear", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.fault_clr = 1'b0;

        // Both limits in IDLE -> FAULT; clear refused while both stay high
        bus.up_limit = 1'b1;
        bus.dn_limit = 1'b1;
        step(1);
        chk_out("both_fault", 1'b0, 1'b0, 1'b0, 1'b1);
        bus.fault_clr = 1'b1;
        step(3);
        chk_out("both_clr_refused", 1'b0, 1'b0, 1'b0, 1'b1);
        bus.up_limit = 1'b0;
        step(1);
        chk_out("both_clr_ok", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.fault_clr = 1'b0;
        bus.dn_limit  = 1'b0;
        step(1);

        // Second press during dead-time cancels; no drive ever asserts
        bus.activate = 1'b1;
        step(1);
        chk_out("cancel_dead", 1'b0, 1'b0, 1'b1, 1'b0);
        bus.activate = 1'b0;
        step(1);
        bus.activate = 1'b1;
        step(1);
        chk_out("cancel_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.activate = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk_out("cancel_quiet", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // last_dir still DN after timeout/cancel -> UP run; reset mid-run drops drive
        bus.activate = 1'b1;
        step(1);
        bus.activate = 1'b0;
        step(4);
        chk_out("rst_run", 1'b1, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        step(1);
        chk_out("rst_mid_run", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1);

        // DN run then obstacle
        bus.up_limit = 1'b1;
        bus.activate = 1'b1;
        step(1);
        bus.activate = 1'b0;
        bus.up_limit = 1'b0;
        step(4);
        chk_out("obs_dn_run", 1'b0, 1'b1, 1'b1, 1'b0);
        bus.obstacle = 1'b1;
        step(1);
        bus.obstacle = 1'b0;
`ifdef OBSTACLE_REVERSE_EN
        chk_out("obs_dead0", 1'b0, 1'b0, 1'b1, 1'b0);
        step(3);
        chk_out("obs_dead3", 1'b0, 1'b0, 1'b1, 1'b0);
        step(1);
        chk_out("obs_reverse_up", 1'b1, 1'b0, 1'b1, 1'b0);
`else
        chk_out("obs_ignored", 1'b0, 1'b1, 1'b1, 1'b0);
        step(4);
        chk_out("obs_ignored_later", 1'b0, 1'b1, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
